// File: rtl/fcs_checker_if.sv
// Byte-stream bus of the RX FCS checker: PSDU bytes in, payload bytes and per-frame status out.
interface fcs_checker_if #(
    parameter int CNT_W = 12
);
    logic             din_valid;
    logic [7:0]       din;
    logic             din_last;
    logic             dout_valid;
    logic [7:0]       dout;
    logic             dout_last;
    logic             fcs_done;
    logic             fcs_ok;
    logic             len_err;
    logic [CNT_W-1:0] frame_len;

    modport master (
        output din_valid, din, din_last,
        input  dout_valid, dout, dout_last, fcs_done, fcs_ok, len_err, frame_len
    );

    modport slave (
        input  din_valid, din, din_last,
        output dout_valid, dout, dout_last, fcs_done, fcs_ok, len_err, frame_len
    );
endinterface

// File: rtl/fcs_checker.sv
// RX-side 802.11 FCS checker: strips the 4-byte FCS, forwards payload, recomputes CRC32 and flags pass/fail.
// Optional good/bad frame counters are enabled with `define FCS_STATS_EN.
module fcs_checker #(
    parameter int MAX_LEN = 4095,
    parameter int CNT_W   = 12
) (
    input logic clk_User,
    input logic reset,
    fcs_checker_if.slave bus
`ifdef FCS_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);
    localparam logic [31:0]      POLY     = 32'h04C1_1DB7;
    localparam logic [CNT_W-1:0] PLEN_MAX = CNT_W'(MAX_LEN - 4);

    typedef enum logic [1:0] {IDLE, FILL, RUN, OVF} state_t;

    state_t           state;
    logic [3:0][7:0]  sr;
    logic [2:0]       fill;
    logic [CNT_W-1:0] plen;
    logic [31:0]      crc;

    logic             run_slot, ovf_hit, emit, short_f, len_bad, match;
    logic [2:0]       fill_nx;
    logic [31:0]      crc_nx;
    logic [CNT_W-1:0] plen_nx;

    // MSB-first, left-shifting CRC32 over one byte.
    function automatic logic [31:0] crc8(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    always_comb begin
        run_slot = (fill == 3'd4) && (state != OVF);
        // Emitting payload index MAX_LEN-4 would mean the PSDU exceeds MAX_LEN.
        ovf_hit  = run_slot && (plen == PLEN_MAX);
        emit     = run_slot && !ovf_hit;
        crc_nx   = emit ? crc8(crc, sr[3]) : crc;
        plen_nx  = plen + CNT_W'(emit);
        fill_nx  = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        short_f  = (fill < 3'd3);
        len_bad  = short_f || (state == OVF) || ovf_hit;
        match    = ({sr[2], sr[1], sr[0], bus.din} == ~crc_nx);
    end

    always_ff @(posedge clk_User) begin
        if (reset) begin
            state          <= IDLE;
            sr             <= '0;
            fill           <= '0;
            plen           <= '0;
            crc            <= 32'hFFFF_FFFF;
            bus.dout_valid <= 1'b0;
            bus.dout       <= '0;
            bus.dout_last  <= 1'b0;
            bus.fcs_done   <= 1'b0;
            bus.fcs_ok     <= 1'b0;
            bus.len_err    <= 1'b0;
            bus.frame_len  <= '0;
`ifdef FCS_STATS_EN
            good_cnt       <= '0;
            bad_cnt        <= '0;
`endif
        end else begin
            bus.dout_valid <= 1'b0;
            bus.dout       <= '0;
            bus.dout_last  <= 1'b0;
            bus.fcs_done   <= 1'b0;
            bus.fcs_ok     <= 1'b0;
            bus.len_err    <= 1'b0;
            bus.frame_len  <= '0;
            if (bus.din_valid) begin
                sr             <= {sr[2:0], bus.din};
                bus.dout_valid <= emit;
                bus.dout       <= emit ? sr[3] : 8'h00;
                if (bus.din_last) begin
                    bus.dout_last <= emit;
                    bus.fcs_done  <= 1'b1;
                    bus.fcs_ok    <= !len_bad && match;
                    bus.len_err   <= len_bad;
                    bus.frame_len <= plen_nx;
`ifdef FCS_STATS_EN
                    if (!len_bad && match) begin
                        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                    end else begin
                        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
                    end
`endif
                    // Reinitialise now so a new frame may start on the very next byte.
                    state <= IDLE;
                    fill  <= '0;
                    plen  <= '0;
                    crc   <= 32'hFFFF_FFFF;
                end else begin
                    fill <= fill_nx;
                    plen <= plen_nx;
                    crc  <= crc_nx;
                    if (state == OVF || ovf_hit) state <= OVF;
                    else if (fill_nx == 3'd4)    state <= RUN;
                    else                         state <= FILL;
                end
            end
        end
    end
endmodule

// File: doc/fcs_checker.md
Name: fcs_checker

Overview:
- Receive-side counterpart of the 802.11 transmit CRC32 generator.
- Consumes a descrambled and decoded PSDU byte stream: payload followed by a 4-byte FCS.
- Forwards the payload with the FCS stripped, recomputes CRC32 over the payload, compares it with the received FCS, and reports a per-frame pass/fail status to the RX MAC-interface logic.

Parameters:
- MAX_LEN, 4095: maximum PSDU length in bytes, FCS included.
- CNT_W, 12: width of the byte counter and frame_len; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk_User  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din_valid  in  1  input byte strobe; gaps between strobes are allowed.
- din  in  8  PSDU byte.
- din_last  in  1  marks the final PSDU byte; sampled only when din_valid=1.
- dout_valid  out  1  payload byte strobe.
- dout  out  8  payload byte; 0 when dout_valid=0.
- dout_last  out  1  marks the final payload byte.
- fcs_done  out  1  one-cycle status pulse per frame.
- fcs_ok  out  1  1 = FCS match; valid when fcs_done=1.
- len_err  out  1  frame shorter than 4 bytes or longer than MAX_LEN; valid when fcs_done=1.
- frame_len  out  CNT_W  payload byte count (PSDU length minus 4); valid when fcs_done=1.

Behaviour:
- Reset:
  - All outputs are 0.
  - crc=0xFFFFFFFF, delay line empty, byte counter 0, state IDLE.
  - A reset mid-frame discards the frame: no fcs_done and no dout_last are produced for it.
- CRC algorithm:
  - Polynomial 0x04C11DB7, left-shifting, 8 bits per update.
  - Per-byte update equations are identical to the transmit generator.
  - Initial value 0xFFFFFFFF.
  - Expected FCS = ~crc, with byte order ~crc[31:24] first through ~crc[7:0] last.
- Delay line:
  - 4-byte shift register sr0 (newest) to sr3 (oldest), plus fill count 0..4.
  - Each accepted byte shifts in.
  - When fill==4, the byte leaving sr3 is a payload byte: it is registered to dout with dout_valid=1 on the next cycle, and crc is updated with it.
- Latency:
  - Payload byte k appears on dout 1 cycle after input byte k+4 is accepted.
  - Throughput is 1 byte/cycle.
- States:
  - IDLE: no bytes of the current frame yet. The first accepted byte goes to FILL, or to IDLE again if din_last is set on it.
  - FILL: fill<4. Goes to RUN when fill reaches 4.
  - RUN: streaming. Goes to OVF when the byte count exceeds MAX_LEN.
  - OVF: keeps accepting bytes, stops dout, stops crc updates, holds len_err until din_last.
  - Any state with an accepted din_last returns to IDLE.
- Frame end (accepted byte with din_last=1):
  - The check compares, oldest first, [sr3..sr0 after the shift] against ~crc_next[31:24], [23:16], [15:8], [7:0]. crc_next includes the payload byte emitted by this same shift.
  - The result is registered: fcs_done=1 on the next cycle.
  - dout_last=1 in the same cycle as that final payload byte's dout_valid, if payload length ≥1.
  - crc, fill and counter are reinitialised in the same cycle, so a new frame's first byte is accepted on the following cycle (back-to-back frames).
- Length boundaries:
  - PSDU < 4 bytes: fcs_done with fcs_ok=0, len_err=1, frame_len=0, and no dout at all.
  - PSDU == 4 bytes: empty payload. crc stays 0xFFFFFFFF, so the expected FCS is 00 00 00 00. No dout and no dout_last; fcs_done only.
  - PSDU > MAX_LEN: fcs_ok=0, len_err=1, frame_len saturates at MAX_LEN-4. Bytes already forwarded remain forwarded, and no dout_last is issued.
- din_last with din_valid=0 is ignored.
- fcs_ok and len_err are never both 1.

Optional Feature:
- FCS_STATS_EN defined:
  - Adds output ports good_cnt[15:0] and bad_cnt[15:0].
  - On each fcs_done, exactly one of them increments, saturating at 0xFFFF.
  - Both are cleared by reset.
- FCS_STATS_EN undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame: 4-byte PSDU 00 00 00 00 with din_last on the 4th byte. Required: no dout_valid, one fcs_done with fcs_ok=1, len_err=0, frame_len=0.
- Good frame: payload 0x01..0x10 (16 bytes) plus FCS from the bench model (~crc, MSB byte first), sent continuously.
  - dout reproduces 0x01..0x10, with the first dout 5 cycles after the first din.
  - dout_last falls on 0x10.
  - fcs_done 1 cycle after the last din, with fcs_ok=1 and frame_len=16.
- Corruption: same frame with bit 0 of the final FCS byte flipped. Required: payload forwarded unchanged; fcs_ok=0, len_err=0.
- Short frame and back-to-back:
  - 3-byte frame AA BB CC, then the 16-byte good frame starting the next cycle.
  - Required: first fcs_done with fcs_ok=0, len_err=1, no dout.
  - The second frame passes as in the 16-byte good-frame case.
- Gaps and overflow:
  - Repeat the 16-byte frame with din_valid deasserted every other cycle. Required: identical dout bytes and status.
  - Then send a 4100-byte frame (MAX_LEN=4095). Required: len_err=1, fcs_ok=0, frame_len=4091, no dout_last.
- Reset mid-frame: reset for 1 cycle after byte 8 of the 16-byte frame, then resend the full frame. Required: no status for the aborted frame; the resent frame passes. With FCS_STATS_EN defined, good_cnt=1 and bad_cnt=0.
